// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_t     - frame FSM states
//   PS2_PREFIX_*    - scan-code prefixes folded into key_ext / key_break
//   PS2_DROP_CODES  - keyboard status bytes that never reach the CPU
package ps2_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_t;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   localparam int PS2_NUM_DROP = 6;
   localparam logic [7:0] PS2_DROP_CODES [PS2_NUM_DROP] =
      '{8'h00, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF};

   function automatic logic ps2_is_dropped(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < PS2_NUM_DROP; i++) hit |= (code == PS2_DROP_CODES[i]);
      return hit;
   endfunction

endpackage

// File: rtl/ps2_key_receiver_filter.sv
// ps2_edge_filter: synchronizes raw PS/2 clock/data and emits a filtered falling-edge strobe.
//   clk, rstn - cpu_clk and asynchronous active-low reset
//   ps2_clk   - raw PS/2 clock (asynchronous)
//   ps2_data  - raw PS/2 data (asynchronous)
//   fall      - one-cycle strobe when the filtered clock goes 1->0
//   data      - synchronized PS/2 data, sampled by the frame FSM on fall
module ps2_edge_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall,
   output logic data
);

   localparam int CW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    clk_s, dat_s;
   logic          filt;
   logic [CW-1:0] cnt;

   assign data = dat_s[1];

   // cnt counts consecutive synchronized samples disagreeing with filt; the
   // FILTER_LEN-th such sample flips filt, and a 1->0 flip raises fall.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clk_s <= 2'b11;
         dat_s <= 2'b11;
         filt  <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         clk_s <= {clk_s[0], ps2_clk};
         dat_s <= {dat_s[0], ps2_data};
         fall  <= 1'b0;
         if (clk_s[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= clk_s[1];
            cnt  <= '0;
            fall <= filt;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard frame receiver with prefix decode and MMIO key register.
//   clk, rstn   - cpu_clk and asynchronous active-low reset
//   ps2_clk     - raw PS/2 clock, ps2_data - raw PS/2 data
//   key_ack     - one-cycle pulse consuming the current code
//   key_data    - last accepted make/break code
//   key_valid   - unread code present
//   key_break   - code was preceded by F0
//   key_ext     - code was preceded by E0
//   key_overrun - sticky, a code was overwritten before ack
//   frame_err   - one-cycle pulse on a discarded frame or timeout
module ps2_key_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       key_ack,
   output logic [7:0] key_data,
   output logic       key_valid,
   output logic       key_break,
   output logic       key_ext,
   output logic       key_overrun,
   output logic       frame_err
);

   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

   logic          fall, din;
   ps2_state_t    state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par, par_n, par_ok, par_ok_n;
   logic [GW-1:0] gap, gap_n;
   logic          emit, err, timeout, load;
   logic          pend_ext, pend_brk;

   ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk      (clk),
      .rstn     (rstn),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .fall     (fall),
      .data     (din)
   );

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_n     = par;
      par_ok_n  = par_ok;
      emit      = 1'b0;
      err       = 1'b0;
      gap_n     = (state == ST_IDLE || fall) ? '0 : gap + 1'b1;
      // gap counts cycles since the last processed fall; the edge that would
      // make it TIMEOUT_CYCLES aborts the frame instead.
      timeout   = (state != ST_IDLE) && !fall && (gap == GW'(TIMEOUT_CYCLES - 1));
      if (timeout) begin
         state_n = ST_IDLE;
         gap_n   = '0;
         err     = 1'b1;
      end else if (fall) begin
         case (state)
            ST_IDLE: begin
               if (!din) begin
                  state_n   = ST_DATA;
                  bit_cnt_n = '0;
                  par_n     = 1'b0;
               end
            end
            ST_DATA: begin
               shreg_n   = {din, shreg[7:1]};
               par_n     = par ^ din;
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = ST_PARITY;
            end
            ST_PARITY: begin
               par_ok_n = par ^ din;
               state_n  = ST_STOP;
            end
            ST_STOP: begin
               emit    = din & par_ok;
               err     = ~(din & par_ok);
               state_n = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
         par_ok  <= 1'b0;
         gap     <= '0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         shreg   <= shreg_n;
         par     <= par_n;
         par_ok  <= par_ok_n;
         gap     <= gap_n;
      end
   end

   assign load = emit && shreg != PS2_PREFIX_EXT && shreg != PS2_PREFIX_BRK && !ps2_is_dropped(shreg);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         key_data    <= '0;
         key_valid   <= 1'b0;
         key_break   <= 1'b0;
         key_ext     <= 1'b0;
         key_overrun <= 1'b0;
         frame_err   <= 1'b0;
         pend_ext    <= 1'b0;
         pend_brk    <= 1'b0;
      end else begin
         frame_err <= err;
         if (err || load) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
         end else if (emit && shreg == PS2_PREFIX_EXT) begin
            pend_ext <= 1'b1;
         end else if (emit && shreg == PS2_PREFIX_BRK) begin
            pend_brk <= 1'b1;
         end
         if (load) begin
            key_data  <= shreg;
            key_ext   <= pend_ext;
            key_break <= pend_brk;
         end
         key_valid   <= load | (key_valid & ~key_ack);
         key_overrun <= (key_ack & key_valid) ? 1'b0 : (load & key_valid) ? 1'b1 : key_overrun;
      end
   end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: scoreboard bench driving PS/2 frames into ps2_key_receiver.
module tb_ps2_key_receiver;

   localparam int FL = 4;
   localparam int TO = 200;
   localparam int H  = 40;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
      logic       brk;
      logic       ext;
      logic       ovr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn, ps2_clk, ps2_data, key_ack;
   logic [7:0] key_data;
   logic       key_valid, key_break, key_ext, key_overrun, frame_err;

   int   n_chk = 0, n_fail = 0;
   int   cyc = 0, last_fall = 0, err_cyc = 0;
   bit   err_seen = 0;
   exp_t q[$];

   logic [7:0] pd;
   logic       pv, pb, pe, po, pf;

   ps2_key_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .key_ack     (key_ack),
      .key_data    (key_data),
      .key_valid   (key_valid),
      .key_break   (key_break),
      .key_ext     (key_ext),
      .key_overrun (key_overrun),
      .frame_err   (frame_err)
   );

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic err, input logic [7:0] d, input logic b, input logic e, input logic o);
      exp_t x;
      x = '{err: err, data: d, brk: b, ext: e, ovr: o};
      q.push_back(x);
   endtask

   task automatic pop_check(input logic is_err);
      exp_t e;
      if (q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_event: got err=%0b data=%0h expected no event", is_err, key_data);
         return;
      end
      e = q.pop_front();
      check("event_kind", is_err, e.err);
      if (!is_err && !e.err) begin
         check("key_data", key_data, e.data);
         check("key_break", key_break, e.brk);
         check("key_ext", key_ext, e.ext);
         check("key_overrun", key_overrun, e.ovr);
      end
   endtask

   // Monitor: a frame_err rise or any newly presented code pops one expectation.
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (frame_err && pf) check("frame_err_width", 1, 0);
         if (frame_err && !pf) begin
            err_cyc  = cyc;
            err_seen = 1;
            pop_check(1'b1);
         end
         if (key_valid && (!pv || key_data != pd || key_break != pb || key_ext != pe || key_overrun != po))
            pop_check(1'b0);
      end
      pv = key_valid; pd = key_data; pb = key_break; pe = key_ext; po = key_overrun; pf = frame_err;
   end

   task automatic send_frame(input logic [7:0] b, input bit bad, input int first, input int last);
      logic [10:0] f;
      f = {1'b1, ~^b ^ bad, b, 1'b0};
      for (int i = first; i <= last; i++) begin
         @(negedge clk) ps2_data = f[i];
         repeat (H) @(negedge clk);
         ps2_clk   = 1'b0;
         last_fall = cyc;
         repeat (H) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (2 * H) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 0, 10);
   endtask

   task automatic ack();
      @(negedge clk) key_ack = 1'b1;
      @(negedge clk) key_ack = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; key_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_key_data", key_data, 8'h00);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_break", key_break, 0);
      check("rst_key_ext", key_ext, 0);
      check("rst_key_overrun", key_overrun, 0);
      check("rst_frame_err", frame_err, 0);
      rstn = 1'b1;
      repeat (5) @(negedge clk);

      push(0, 8'h1C, 0, 0, 0); send(8'h1C); ack();
      push(0, 8'h1C, 1, 0, 0); send(8'hF0); send(8'h1C); ack();
      push(0, 8'h75, 1, 1, 0); send(8'hE0); send(8'hF0); send(8'h75); ack();
      push(0, 8'h1C, 0, 0, 0); send(8'h1C); ack();
      push(0, 8'h5A, 0, 0, 0); send(8'hAA); send(8'hFA); send(8'h5A); ack();

      push(1, 8'h00, 0, 0, 0); send_frame(8'h1C, 1'b1, 0, 10);
      check("bad_parity_no_valid", key_valid, 0);
      push(0, 8'h1C, 0, 0, 0); send(8'h1C); ack();

      err_seen = 0;
      push(1, 8'h00, 0, 0, 0); send_frame(8'h2A, 1'b0, 0, 4);
      for (int i = 0; i < TO + 50 && !err_seen; i++) @(negedge clk);
      check("timeout_seen", err_seen, 1);
      check("timeout_cycles", err_cyc - last_fall, 3 + FL + TO);
      push(0, 8'h2A, 0, 0, 0); send(8'h2A); ack();

      push(0, 8'h1C, 0, 0, 0); push(0, 8'h32, 0, 0, 1);
      send(8'h1C); send(8'h32);
      ack();
      check("ack_valid", key_valid, 0);
      check("ack_overrun", key_overrun, 0);
      check("ack_data_held", key_data, 8'h32);

      push(0, 8'h1C, 0, 0, 0); send(8'h1C);
      check("pre_rst_valid", key_valid, 1);
      send_frame(8'h2A, 1'b0, 0, 3);
      rstn = 1'b0;
      #1;
      check("midrst_key_data", key_data, 8'h00);
      check("midrst_key_valid", key_valid, 0);
      check("midrst_key_break", key_break, 0);
      check("midrst_key_ext", key_ext, 0);
      check("midrst_key_overrun", key_overrun, 0);
      check("midrst_frame_err", frame_err, 0);
      send_frame(8'h2A, 1'b0, 4, 10);
      @(negedge clk) rstn = 1'b1;
      repeat (TO + 50) @(negedge clk);
      check("post_rst_valid", key_valid, 0);
      check("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
